// File: rtl/steer_en_sm.sv
// steer_en_sm: rider-detect and steering-enable controller.
// Sums and compares the left/right load cells and enables steering only after
// the rider has stood balanced for a full balance-timer interval.
// Optional build macro: STEER_EN_DEBOUNCE_EN (requires four consecutive
// low-load cycles before leaving WAIT/STEER for IDLE).
module steer_en_sm #(
  parameter logic [11:0] MIN_RIDER_WT  = 12'h200,
  parameter logic [11:0] WT_HYSTERESIS = 12'h040,
  parameter bit          fast_sim      = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] lft_ld,
  input  logic [11:0] rght_ld,
  output logic        en_steer,
  output logic        rider_off
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    STEER = 2'd2
  } state_t;

  localparam logic [12:0] MIN_W = {1'b0, MIN_RIDER_WT};
  localparam logic [12:0] LOW_W = {1'b0, MIN_RIDER_WT} - {1'b0, WT_HYSTERESIS};

  state_t      state_q, state_d;
  logic [25:0] tmr_q;
  logic        clr_tmr;
  logic        tmr_full;
  logic        en_steer_q;
  logic        rider_off_q;

  logic [12:0] sum, diff, sum_qtr, sum_15_16;
  logic        sum_gt_min, sum_lt_min, diff_gt_1_4, diff_gt_15_16;
  logic        low_exit;

  // Load arithmetic and threshold comparisons, all in 13 bits so nothing overflows
  always_comb begin
    sum = {1'b0, lft_ld} + {1'b0, rght_ld};
    if (lft_ld >= rght_ld) diff = {1'b0, lft_ld} - {1'b0, rght_ld};
    else                   diff = {1'b0, rght_ld} - {1'b0, lft_ld};
    sum_qtr       = sum >> 2;
    sum_15_16     = sum - (sum >> 4);
    sum_gt_min    = (sum > MIN_W);
    sum_lt_min    = (sum < LOW_W);
    diff_gt_1_4   = (diff > sum_qtr);
    diff_gt_15_16 = (diff > sum_15_16);
    tmr_full      = fast_sim ? (&tmr_q[14:0]) : (&tmr_q);
  end

`ifdef STEER_EN_DEBOUNCE_EN
  logic [1:0] low_cnt_q, low_cnt_d;

  // Count consecutive low-load cycles, saturating at 3; any non-low cycle clears it
  always_comb begin
    low_cnt_d = low_cnt_q;
    if (!sum_lt_min)              low_cnt_d = '0;
    else if (low_cnt_q != 2'd3)   low_cnt_d = low_cnt_q + 2'd1;
    low_exit = sum_lt_min && (low_cnt_q == 2'd3);
  end

  // Debounce counter register
  always_ff @(posedge clk) begin
    if (rst) low_cnt_q <= '0;
    else     low_cnt_q <= low_cnt_d;
  end
`else
  // Without debounce a single low-load cycle is enough to drop the rider
  always_comb begin
    low_exit = sum_lt_min;
  end
`endif

  // Balance timer: clears on request, otherwise counts up and sticks at all-ones
  always_ff @(posedge clk) begin
    if (rst)               tmr_q <= '0;
    else if (clr_tmr)      tmr_q <= '0;
    else if (!(&tmr_q))    tmr_q <= tmr_q + 26'd1;
  end

  // Next-state and timer-clear decode; rider loss always outranks imbalance
  always_comb begin
    state_d = state_q;
    clr_tmr = 1'b0;
    case (state_q)
      IDLE: begin
        if (sum_gt_min) begin
          state_d = WAIT;
          clr_tmr = 1'b1;
        end
      end
      WAIT: begin
        if (low_exit)          state_d = IDLE;
        else if (diff_gt_1_4)  clr_tmr = 1'b1;
        else if (tmr_full)     state_d = STEER;
      end
      STEER: begin
        if (low_exit) begin
          state_d = IDLE;
        end else if (diff_gt_15_16) begin
          state_d = WAIT;
          clr_tmr = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; outputs are registered from the next state so they move with it
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      en_steer_q  <= 1'b0;
      rider_off_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      en_steer_q  <= (state_d == STEER);
      rider_off_q <= (state_d == IDLE);
    end
  end

  assign en_steer  = en_steer_q;
  assign rider_off = rider_off_q;

endmodule
